power_averager: RTL and testbench

POWER_AVERAGER -- requirements
Module: power_averager

---
 rtl/power_averager.sv | 140 ++++++++++++++
 tb/tb_power_averager.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/power_averager.sv
// Windowed mean-power estimator for carrier sense: squares I/Q samples, keeps a
// running sum over the last 2^LOG2_WIN powers and outputs the truncated mean.
module power_averager #(
    parameter int unsigned LOG2_WIN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        run_rx0,
    input  logic [31:0] sample_in,
    input  logic        strobe,
    output logic [31:0] average,
    output logic        average_valid
);

    localparam int unsigned W  = 1 << LOG2_WIN;
    localparam int unsigned SW = 32 + LOG2_WIN;
    localparam logic [LOG2_WIN:0]   FILL_FULL = {1'b1, {LOG2_WIN{1'b0}}};
    localparam logic [LOG2_WIN-1:0] PTR_ONE   = LOG2_WIN'(1'b1);
    localparam logic [LOG2_WIN:0]   FILL_ONE  = (LOG2_WIN + 1)'(1'b1);

    // 31-bit signed arithmetic holds the bit pattern of x*x exactly (max 2^30).
    function automatic logic [30:0] square16(input logic signed [15:0] x);
        logic signed [30:0] xe;
        xe = 31'(x);
        return $unsigned(xe * xe);
    endfunction

    logic                accept_s;
    logic                hist_we_s;
    logic [31:0]         old_s;

    logic                v1_q, v1_d;
    logic [30:0]         ii_q, ii_d;
    logic [30:0]         qq_q, qq_d;
    logic                v2_q, v2_d;
    logic [31:0]         p_q, p_d;
    logic [SW-1:0]       sum_q, sum_d;
    logic [LOG2_WIN-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_WIN:0]   fill_cnt_q, fill_cnt_d;
    logic [31:0]         average_q, average_d;
    logic                average_valid_q, average_valid_d;
    logic [31:0]         hist_q [W];

    // Next-state logic for the square / add / accumulate / divide pipeline.
    always_comb begin
        accept_s        = strobe & enable & run_rx0;
        hist_we_s       = 1'b0;
        old_s           = 32'd0;
        v1_d            = v1_q;
        ii_d            = ii_q;
        qq_d            = qq_q;
        v2_d            = v2_q;
        p_d             = p_q;
        sum_d           = sum_q;
        wr_ptr_d        = wr_ptr_q;
        fill_cnt_d      = fill_cnt_q;
        average_d       = average_q;
        average_valid_d = average_valid_q;

        if (!enable) begin
            v1_d            = 1'b0;
            v2_d            = 1'b0;
            sum_d           = {SW{1'b0}};
            wr_ptr_d        = {LOG2_WIN{1'b0}};
            fill_cnt_d      = {(LOG2_WIN + 1){1'b0}};
            average_d       = 32'd0;
            average_valid_d = 1'b0;
        end else begin
            // Stages already holding a sample keep draining even if run_rx0 drops.
            v1_d = accept_s;
            if (accept_s) begin
                ii_d = square16(sample_in[31:16]);
                qq_d = square16(sample_in[15:0]);
            end else begin
                ii_d = ii_q;
                qq_d = qq_q;
            end

            v2_d = v1_q;
            p_d  = {1'b0, ii_q} + {1'b0, qq_q};

            if (v2_q) begin
                hist_we_s = 1'b1;
                if (fill_cnt_q == FILL_FULL) begin
                    old_s      = hist_q[wr_ptr_q];
                    fill_cnt_d = fill_cnt_q;
                end else begin
                    old_s      = 32'd0;
                    fill_cnt_d = fill_cnt_q + FILL_ONE;
                end
                sum_d    = sum_q + SW'(p_q) - SW'(old_s);
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                hist_we_s = 1'b0;
            end

            average_d       = sum_q[31+LOG2_WIN:LOG2_WIN];
            average_valid_d = (fill_cnt_q == FILL_FULL);
        end
    end

    // Pipeline and accumulator state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q            <= 1'b0;
            ii_q            <= 31'd0;
            qq_q            <= 31'd0;
            v2_q            <= 1'b0;
            p_q             <= 32'd0;
            sum_q           <= {SW{1'b0}};
            wr_ptr_q        <= {LOG2_WIN{1'b0}};
            fill_cnt_q      <= {(LOG2_WIN + 1){1'b0}};
            average_q       <= 32'd0;
            average_valid_q <= 1'b0;
        end else begin
            v1_q            <= v1_d;
            ii_q            <= ii_d;
            qq_q            <= qq_d;
            v2_q            <= v2_d;
            p_q             <= p_d;
            sum_q           <= sum_d;
            wr_ptr_q        <= wr_ptr_d;
            fill_cnt_q      <= fill_cnt_d;
            average_q       <= average_d;
            average_valid_q <= average_valid_d;
        end
    end

    // History buffer: never cleared; stale entries are masked by fill_cnt.
    always_ff @(posedge clk) begin
        if (!rst && hist_we_s) begin
            hist_q[wr_ptr_q] <= p_q;
        end
    end

    assign average       = average_q;
    assign average_valid = average_valid_q;

endmodule

// File: tb/tb_power_averager.sv
// Directed and table-driven checks of power_averager with a 16-sample window.
module tb_power_averager;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        run_rx0;
    logic [31:0] sample_in;
    logic        strobe;
    logic [31:0] average;
    logic        average_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stb;
        logic [15:0] i;
        logic [15:0] q;
        logic [31:0] avg;
        logic        vld;
    } vec_t;

    vec_t   tbl [35];
    longint pw  [20];

    power_averager #(.LOG2_WIN(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .run_rx0       (run_rx0),
        .sample_in     (sample_in),
        .strobe        (strobe),
        .average       (average),
        .average_valid (average_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic stb, input logic [15:0] i, input logic [15:0] q,
                       input logic en, input logic run, input logic rs);
        strobe    = stb;
        sample_in = {i, q};
        enable    = en;
        run_rx0   = run;
        rst       = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0);
    endtask

    // Reset, then a full window of p = 10000 (I=100, Q=0).
    task automatic fill_window();
        cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 16; k++) cyc(1'b1, 16'd100, 16'd0, 1'b1, 1'b1, 1'b0);
        idle(4);
    endtask

    initial begin
        longint s;
        logic [15:0] ri, rq;
        int si, sq;

        // Records apply one cycle each; expected values are sampled after that edge.
        for (int k = 0; k < 35; k++) begin
            tbl[k].stb = (k < 32);
            tbl[k].i   = (k < 16) ? 16'd100 : 16'h8000;
            tbl[k].q   = (k < 16) ? 16'd0   : 16'h8000;
            if (k < 3)       tbl[k].avg = 32'd0;
            else if (k < 19) tbl[k].avg = 32'(625 * (k - 2));
            else             tbl[k].avg = 32'(64'd10000 + 64'(k - 18) * 64'd134217103);
            tbl[k].vld = (k >= 18);
        end

        strobe = 1'b0; sample_in = 32'd0; enable = 1'b0; run_rx0 = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        // Reset has priority over an enabled block.
        cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1);
        chk("reset_avg", average, 32'd0);
        chk("reset_valid", {31'd0, average_valid}, 32'd0);

        for (int k = 0; k < 35; k++) begin
            cyc(tbl[k].stb, tbl[k].i, tbl[k].q, 1'b1, 1'b1, 1'b0);
            chk($sformatf("tbl_avg[%0d]", k), average, tbl[k].avg);
            chk($sformatf("tbl_valid[%0d]", k), {31'd0, average_valid}, {31'd0, tbl[k].vld});
        end
        chk("max_power_no_wrap", average, 32'h8000_0000);

        // run_rx0 low: strobes ignored, average holds.
        fill_window();
        chk("fill_avg", average, 32'd10000);
        for (int k = 0; k < 5; k++) cyc(1'b1, 16'd1000, 16'd1000, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("run_low_avg", average, 32'd10000);
        chk("run_low_valid", {31'd0, average_valid}, 32'd1);
        // One sample accepted just before run_rx0 falls still lands.
        cyc(1'b1, 16'd1000, 16'd1000, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b1, 16'd1000, 16'd1000, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("inflight_run_avg", average, 32'd134375);

        // enable pulse low (with a coincident strobe), then a fresh window.
        fill_window();
        cyc(1'b1, 16'd100, 16'd0, 1'b0, 1'b1, 1'b0);
        chk("disable_avg", average, 32'd0);
        chk("disable_valid", {31'd0, average_valid}, 32'd0);
        cyc(1'b1, 16'd0, 16'd400, 1'b1, 1'b1, 1'b0);
        idle(3);
        chk("reenable_avg", average, 32'd10000);
        chk("reenable_valid", {31'd0, average_valid}, 32'd0);

        // Reset with three samples in flight.
        fill_window();
        for (int k = 0; k < 3; k++) cyc(1'b1, 16'd1000, 16'd1000, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1);
        chk("midrst_avg", average, 32'd0);
        chk("midrst_valid", {31'd0, average_valid}, 32'd0);
        idle(5);
        chk("midrst_late_avg", average, 32'd0);
        chk("midrst_late_valid", {31'd0, average_valid}, 32'd0);

        // Sparse random samples against a sliding-window reference.
        cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1);
        idle(1);
        for (int j = 0; j <= 20; j++) begin
            if (j < 20) begin
                ri = 16'($urandom);
                rq = 16'($urandom);
                si = int'($signed(ri));
                sq = int'($signed(rq));
                pw[j] = longint'(si) * longint'(si) + longint'(sq) * longint'(sq);
                cyc(1'b1, ri, rq, 1'b1, 1'b1, 1'b0);
            end else begin
                cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0);
            end
            if (j > 0) begin
                s = 0;
                for (int m = (j > 16 ? j - 16 : 0); m < j; m++) s += pw[m];
                chk($sformatf("rand_avg[%0d]", j - 1), average, 32'(s >> 4));
                chk($sformatf("rand_valid[%0d]", j - 1), {31'd0, average_valid},
                    (j >= 16) ? 32'd1 : 32'd0);
            end
            if (j < 20) idle(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
